// File: rtl/mem_arb_pkg.sv
// Shared encodings for the mem_arb two-port memory arbiter.
// Optional build macro: MEM_ARB_RR_EN (round-robin arbitration instead of fixed D-over-I).
package mem_arb_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_e;

    // Owner encoding; the two values are complements, so "the other port" is a bit flip
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for mem_arb.
// Optional build macro: MEM_ARB_RR_EN selects round-robin; otherwise D always beats I.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant,
    output logic owner
);

    // Pick the winning port from the live requests
    always_comb begin
        grant = i_req | d_req;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            // Contention: the port not served last time wins
            owner = ~last_grant;
        end else begin
            owner = d_req ? OWN_D : OWN_I;
        end
`else
        // D wins whenever it asks; with no requester the select parks on last_grant
        owner = d_req ? OWN_D : (i_req ? OWN_I : last_grant);
`endif
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one mem_system between the instruction port (I) and data port (D).
// A winning request is latched, driven to mem_system until Done, then acknowledged
// to its owner with a one-cycle registered pulse.
// Optional build macro: MEM_ARB_RR_EN (round-robin arbitration with a last-grant flop).
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_hit,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_hit,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    input  logic          mem_hit,
    input  logic          mem_err
);

    arb_state_e state_q;
    logic       owner_q;
    logic       last_grant;
    logic       pick_grant;
    logic       pick_owner;

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;

    // Round-robin pointer: remembers the port granted most recently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= OWN_D;
        end else if (state_q == ARB_IDLE && pick_grant) begin
            last_grant_q <= pick_owner;
        end
    end

    assign last_grant = last_grant_q;
`else
    // Fixed priority keeps no pointer; the owner register only parks the idle select
    assign last_grant = owner_q;
`endif

    // Arbitration sequencer; every mem_system and response output is a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_D;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            i_hit     <= 1'b0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            d_hit     <= 1'b0;
            err       <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_grant) begin
                        owner_q <= pick_owner;
                        state_q <= ARB_BUSY;
                        if (pick_owner == OWN_D) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_rd    <= ~d_wr;
                            mem_wr    <= d_wr;
                        end else begin
                            // Port I only ever reads
                            mem_addr <= i_addr;
                            mem_rd   <= 1'b1;
                            mem_wr   <= 1'b0;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (mem_done) begin
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        state_q <= ARB_RESP;
                        if (mem_err) begin
                            err <= 1'b1;
                        end
                        if (owner_q == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_hit   <= mem_hit;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_hit   <= mem_hit;
                            i_ack   <= 1'b1;
                        end
                    end
                end
                ARB_RESP: begin
                    // The ack pulse raised on Done is visible for this single cycle
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
